width_16to8: RTL and testbench
==============================

# width_16to8

Downstream companion to the 8-to-16 widener: it accepts 16-bit words with a valid/ready handshake and re-serializes each word into two 8-bit bytes on a byte-wide valid/ready output. A 2-entry word buffer decouples the two sides, so the upstream widener can deliver a word while the previous one is still being drained. It sits between the 16-bit processing domain and a byte-wide sink (link/serializer) that may apply backpressure.

## Interface
- MSB_FIRST, default 1: 1 = emit data_in[15:8] then [7:0]; 0 = emit [7:0] then [15:8].
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- valid_in  input  1  upstream word valid.
- data_in  input  16  upstream word; sampled when valid_in && ready_in.
- ready_in  output  1  block can accept a word this cycle.
- valid_out  output  1  data_out holds a valid byte.
- data_out  output  8  output byte.
- ready_out  input  1  downstream accepts the byte this cycle.

## Operation
- Storage: 2 × 16-bit word buffer, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2), 1-bit phase (0 = first byte of head word, 1 = second byte).
- Push: on valid_in && ready_in, write data_in at the write pointer, advance it (wraps 1→0), count+1.
- ready_in = (count != 2) and not in reset. No full-bypass: when count == 2, ready_in is 0 even if a pop occurs in the same cycle.
- Output: valid_out = (count != 0). data_out = head word byte selected by phase and MSB_FIRST; byte 0 when count == 0.
- Byte transfer on valid_out && ready_out:
  - phase 0 → phase 1; word stays in the buffer.
  - phase 1 → phase 0; pop: advance the read pointer (wraps), count−1.
- Simultaneous push and pop (count 1, second byte taken, new word accepted): count stays 1 and both pointers advance.
- valid_in is ignored while ready_in = 0; the word is not captured.
- Stability: while valid_out = 1 and ready_out = 0, data_out, phase and the head word hold unchanged.
- Reset, asynchronous, during rst = 1: count = 0, both pointers = 0, phase = 0, buffer cleared to 0.
  - Outputs: valid_out = 0, data_out = 8'h00, ready_in = 0.
  - A partially drained word (phase 1) is discarded.
- No overflow or underflow is possible. Push is gated by ready_in; pop is gated by valid_out.

## Timing
- Latency: a word accepted at edge N gives valid_out = 1 and its first byte on data_out right after edge N. The second byte follows after the first edge at which ready_out = 1.
- Throughput: one word per 2 cycles with ready_out held at 1. The output is then continuously valid provided upstream presents a word at least every 2 cycles.
- ready_in rises in the first cycle after rst deasserts.
- ready_in falls right after the edge at which count becomes 2.
- ready_in rises right after the edge that pops a word from a full buffer.
- All outputs are functions of registered state only. There is no combinational path from valid_in/data_in or ready_out to any output.

## Test plan
- Reset check: assert rst mid-cycle → valid_out = 0, data_out = 00 and ready_in = 0 immediately, with no clock edge. After release, ready_in = 1 from the next cycle.
- Basic word, MSB_FIRST = 1, ready_out tied 1: push 16'hA55A → data_out A5 in the cycle after the push, then 5A, then valid_out = 0. Repeat with MSB_FIRST = 0 → 5A, then A5.
- Back-to-back stream: push 1234, 5678 and 9ABC as fast as ready_in allows, with ready_out = 1 → bytes 12 34 56 78 9A BC with no valid_out gaps after the first byte. Check the pointer wrap on the third word.
- Backpressure and full:
  - Hold ready_out = 0 and push 1111, 2222 → ready_in = 0 after the second push.
  - A third word (3333) offered while ready_in = 0 is not captured.
  - data_out stays 11 for ≥5 cycles.
  - Release ready_out → 11 11 22 22; ready_in returns to 1 after the first pop.
- Simultaneous push/pop at count 1: during the second byte of BEEF, push CAFE in the same cycle that EF is taken → next bytes CA FE, with count 1 then 0.
- Reset mid-word: push DEAD, take DE, then pulse rst → AD is never output. After reset, push 0102 → output 01 02.

Source files
------------

// File: rtl/width_16to8_if.sv
// width_16to8_if: handshake bundle for the 16-to-8 narrower.
//   Upstream word side : valid_in, data_in[15:0], ready_in
//   Downstream byte side: valid_out, data_out[7:0], ready_out
//   Modport slave  : the narrower's view.
//   Modport master : the environment's view (drives words in, sinks bytes).
interface width_16to8_if;
  logic        valid_in;
  logic [15:0] data_in;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        ready_out;

  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_out,
    output ready_in,
    output valid_out,
    output data_out
  );

  modport master (
    output valid_in,
    output data_in,
    output ready_out,
    input  ready_in,
    input  valid_out,
    input  data_out
  );
endinterface

// File: rtl/width_16to8.sv
// width_16to8: re-serialises 16-bit words into pairs of bytes.
//   A 2-entry word buffer decouples the word side from the byte side so a new
//   word can be accepted while the previous one is still being drained.
// Parameters:
//   MSB_FIRST  1: emit [15:8] then [7:0]; 0: emit [7:0] then [15:8].
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset, clears all state
//   bus   width_16to8_if.slave (valid_in/data_in/ready_in word side,
//         valid_out/data_out/ready_out byte side)
// All outputs decode registered state only.
module width_16to8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  width_16to8_if.slave  bus
);

  logic [15:0] word_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        phase_q;
  // Set on the first edge after reset release; holds ready_in low until then
  // without a combinational path from rst to ready_in.
  logic        alive_q;

  logic        ready_in;
  logic        valid_out;
  logic        push;
  logic        pop_byte;
  logic        pop_word;
  logic [15:0] head;

  assign ready_in  = alive_q && (count_q != 2'd2);
  assign valid_out = (count_q != 2'd0);
  assign head      = word_q[rd_ptr_q];

  assign push      = bus.valid_in && ready_in;
  assign pop_byte  = valid_out && bus.ready_out;
  assign pop_word  = pop_byte && phase_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop_word})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q[0] <= '0;
      word_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      phase_q   <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (push) begin
        word_q[wr_ptr_q] <= bus.data_in;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_byte) begin
        phase_q <= ~phase_q;
      end
      if (pop_word) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Low byte goes out on phase 1 when MSB first, on phase 0 otherwise.
  always_comb begin
    bus.data_out = 8'h00;
    if (valid_out) begin
      bus.data_out = (phase_q == MSB_FIRST) ? head[7:0] : head[15:8];
    end
  end

  assign bus.ready_in  = ready_in;
  assign bus.valid_out = valid_out;

endmodule

// File: tb/tb_width_16to8.sv
module tb_width_16to8;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  width_16to8_if bus ();
  width_16to8_if bus2 ();

  width_16to8 #(.MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  width_16to8 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    step();
    vectors++;
    if (bus.ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", bus.ready_in);
    end
    // Load a word, then reset mid-cycle with no clock edge.
    bus.valid_in = 1'b1; bus.data_in = 16'h7E7E; bus.ready_out = 1'b0;
    step();
    bus.valid_in = 1'b0;
    vectors++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h7E) begin
      miscompares++;
      $display("FAIL reset_preload: got v=%b d=%h want v=1 d=7e", bus.valid_out, bus.data_out);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00 || bus.ready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got v=%b d=%h r=%b want v=0 d=00 r=0",
               bus.valid_out, bus.data_out, bus.ready_in);
    end
    #2 rst = 1'b0;
    vectors++;
    if (bus.ready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_before_edge: got %b want 0", bus.ready_in);
    end
    step();
    vectors++;
    if (bus.ready_in !== 1'b1 || bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after_release: got r=%b v=%b want r=1 v=0",
               bus.ready_in, bus.valid_out);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_msb [2];
    logic [7:0] exp_lsb [2];
    exp_msb[0] = 8'hA5; exp_msb[1] = 8'h5A;
    exp_lsb[0] = 8'h5A; exp_lsb[1] = 8'hA5;
    bus.valid_in  = 1'b1; bus.data_in  = 16'hA55A; bus.ready_out  = 1'b1;
    bus2.valid_in = 1'b1; bus2.data_in = 16'hA55A; bus2.ready_out = 1'b1;
    step();
    bus.valid_in = 1'b0; bus2.valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp_msb[i]) begin
        miscompares++;
        $display("FAIL basic_msb_byte%0d: got v=%b d=%h want v=1 d=%h",
                 i, bus.valid_out, bus.data_out, exp_msb[i]);
      end
      vectors++;
      if (bus2.valid_out !== 1'b1 || bus2.data_out !== exp_lsb[i]) begin
        miscompares++;
        $display("FAIL basic_lsb_byte%0d: got v=%b d=%h want v=1 d=%h",
                 i, bus2.valid_out, bus2.data_out, exp_lsb[i]);
      end
      step();
    end
    vectors++;
    if (bus.valid_out !== 1'b0 || bus2.valid_out !== 1'b0 || bus.data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL basic_drained: got v=%b v2=%b d=%h want v=0 v2=0 d=00",
               bus.valid_out, bus2.valid_out, bus.data_out);
    end
    bus2.ready_out = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [7:0]  bytes [6];
    int          idx;
    int          nbytes;
    logic        rdy;
    logic        offered;
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
    bytes[3] = 8'h78; bytes[4] = 8'h9A; bytes[5] = 8'hBC;
    idx = 0;
    nbytes = 0;
    bus.ready_out = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      rdy     = bus.ready_in;
      offered = (idx < 3);
      bus.valid_in = offered;
      bus.data_in  = offered ? words[idx] : 16'h0000;
      step();
      if (offered && rdy) idx++;
      if (bus.valid_out === 1'b1 && nbytes < 6) begin
        vectors++;
        if (bus.data_out !== bytes[nbytes]) begin
          miscompares++;
          $display("FAIL b2b_byte%0d: got %h want %h", nbytes, bus.data_out, bytes[nbytes]);
        end
        nbytes++;
      end else if (nbytes > 0 && nbytes < 6) begin
        vectors++;
        miscompares++;
        $display("FAIL b2b_gap: valid_out low after %0d bytes, want continuous", nbytes);
      end
    end
    bus.valid_in = 1'b0;
    vectors++;
    if (nbytes != 6 || bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_total: got %0d bytes v=%b want 6 bytes v=0", nbytes, bus.valid_out);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4];
    logic       exp_r [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h22;
    exp_r[0] = 1'b0;  exp_r[1] = 1'b0;  exp_r[2] = 1'b1;  exp_r[3] = 1'b1;
    bus.ready_out = 1'b0;
    bus.valid_in = 1'b1; bus.data_in = 16'h1111;
    step();
    bus.data_in = 16'h2222;
    step();
    vectors++;
    if (bus.ready_in !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== 8'h11) begin
      miscompares++;
      $display("FAIL bp_full: got r=%b v=%b d=%h want r=0 v=1 d=11",
               bus.ready_in, bus.valid_out, bus.data_out);
    end
    bus.data_in = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus.ready_in !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== 8'h11) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got r=%b v=%b d=%h want r=0 v=1 d=11",
                 i, bus.ready_in, bus.valid_out, bus.data_out);
      end
    end
    bus.valid_in = 1'b0;
    bus.ready_out = 1'b1;
    // Sequence seen after each edge: 11(2nd), 22, 22(2nd), then empty.
    for (int i = 1; i < 4; i++) begin
      step();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp_d[i] || bus.ready_in !== exp_r[i]) begin
        miscompares++;
        $display("FAIL bp_drain%0d: got v=%b d=%h r=%b want v=1 d=%h r=%b",
                 i, bus.valid_out, bus.data_out, bus.ready_in, exp_d[i], exp_r[i]);
      end
    end
    step();
    vectors++;
    if (bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_3333: got v=%b d=%h want v=0", bus.valid_out, bus.data_out);
    end
  endtask

  task automatic test_simul_push_pop();
    bus.ready_out = 1'b1;
    bus.valid_in = 1'b1; bus.data_in = 16'hBEEF;
    step();
    bus.valid_in = 1'b0;
    vectors++;
    if (bus.data_out !== 8'hBE) begin
      miscompares++;
      $display("FAIL simul_be: got %h want be", bus.data_out);
    end
    step();
    vectors++;
    if (bus.data_out !== 8'hEF || bus.ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_ef: got d=%h r=%b want d=ef r=1", bus.data_out, bus.ready_in);
    end
    bus.valid_in = 1'b1; bus.data_in = 16'hCAFE;
    step();
    bus.valid_in = 1'b0;
    vectors++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hCA || bus.ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_ca: got v=%b d=%h r=%b want v=1 d=ca r=1",
               bus.valid_out, bus.data_out, bus.ready_in);
    end
    step();
    vectors++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hFE) begin
      miscompares++;
      $display("FAIL simul_fe: got v=%b d=%h want v=1 d=fe", bus.valid_out, bus.data_out);
    end
    step();
    vectors++;
    if (bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_empty: got v=%b want 0", bus.valid_out);
    end
  endtask

  task automatic test_reset_mid_word();
    bus.ready_out = 1'b1;
    bus.valid_in = 1'b1; bus.data_in = 16'hDEAD;
    step();
    bus.valid_in = 1'b0;
    vectors++;
    if (bus.data_out !== 8'hDE) begin
      miscompares++;
      $display("FAIL rmid_de: got %h want de", bus.data_out);
    end
    step();
    bus.ready_out = 1'b0;
    vectors++;
    if (bus.data_out !== 8'hAD) begin
      miscompares++;
      $display("FAIL rmid_ad_pending: got %h want ad", bus.data_out);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rmid_reset: got v=%b d=%h want v=0 d=00", bus.valid_out, bus.data_out);
    end
    #2 rst = 1'b0;
    bus.ready_out = 1'b1;
    step();
    vectors++;
    if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_discard: got v=%b d=%h r=%b want v=0 r=1",
               bus.valid_out, bus.data_out, bus.ready_in);
    end
    bus.valid_in = 1'b1; bus.data_in = 16'h0102;
    step();
    bus.valid_in = 1'b0;
    vectors++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h01) begin
      miscompares++;
      $display("FAIL rmid_01: got v=%b d=%h want v=1 d=01", bus.valid_out, bus.data_out);
    end
    step();
    vectors++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h02) begin
      miscompares++;
      $display("FAIL rmid_02: got v=%b d=%h want v=1 d=02", bus.valid_out, bus.data_out);
    end
    step();
    vectors++;
    if (bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_empty: got v=%b want 0", bus.valid_out);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.valid_in  = 1'b0; bus.data_in  = 16'h0000; bus.ready_out  = 1'b0;
    bus2.valid_in = 1'b0; bus2.data_in = 16'h0000; bus2.ready_out = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
